// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE,
        RSP_I,
        RSP_D,
        RSP_DERR
    } rsp_t;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;
    localparam logic [2:0] F3_LW = 3'b010;

    function automatic logic bad_access(input logic [1:0] sz,
                                        input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        unique case (sz)
            BYTE: bad = 1'b0;
            HALF: bad = a[0];
            WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0] is fetch, req[1] is data.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // 1 when data was granted most recently
    logic last_d;

    assign gnt[0] = req[0] & (~req[1] | last_d);
    assign gnt[1] = req[1] & (~req[0] | ~last_d);

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_d <= 1'b0;
        end else if (accept) begin
            last_d <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-cycle memory port between instruction fetch and
// load/store, with round-robin grant and one-cycle responses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    logic              bad;
    rsp_t              state, state_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [2:0]        f3_q, sel_f3;
    logic [DATA_W-1:0] din_q, sel_din;

    assign req    = {d_req, i_req} & {2{reset}};
    assign i_gnt  = gnt[0];
    assign d_gnt  = gnt[1];
    assign accept = gnt[0] | gnt[1];
    assign bad    = bad_access(d_funct3[1:0], d_addr[1:0]);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign sel_addr   = d_gnt ? d_addr : i_addr;
    assign sel_f3     = d_gnt ? d_funct3 : F3_LW;
    assign sel_din    = d_gnt ? d_wdata : '0;
    // Idle cycles replay the last address so the read mux stays put
    assign mem_addr   = accept ? sel_addr : addr_q;
    assign mem_funct3 = accept ? sel_f3 : f3_q;
    assign mem_din    = accept ? sel_din : din_q;
    assign mem_write  = d_gnt & d_we & ~bad;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= NONE;
            we_q   <= 1'b0;
            addr_q <= '0;
            f3_q   <= F3_LW;
            din_q  <= '0;
        end else begin
            state <= state_nx;
            we_q  <= d_gnt & d_we;
            if (accept) begin
                addr_q <= sel_addr;
                f3_q   <= sel_f3;
                din_q  <= sel_din;
            end
        end
    end

    always_comb begin
        state_nx = NONE;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        if (i_gnt) begin
            state_nx = RSP_I;
        end else if (d_gnt) begin
            state_nx = bad ? RSP_DERR : RSP_D;
        end
        if (reset) begin
            unique case (state)
                RSP_I: begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_dout;
                end
                RSP_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = we_q ? '0 : mem_dout;
                end
                RSP_DERR: begin
                    d_rvalid = 1'b1;
                    d_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a behavioural banked memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [12:0] i_addr, d_addr;
    logic [2:0]  d_funct3;
    logic [31:0] d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [12:0] mem_addr;
    logic [31:0] mem_din, mem_dout;

    logic [31:0] mem [0:2047];
    int checks = 0;
    int failures = 0;
    int wr_pulses = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_funct3   (d_funct3),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_write  (mem_write),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Byte-lane write, registered full-word read
    always @(posedge clk) begin
        logic [31:0] w;
        w = mem[mem_addr[12:2]];
        mem_dout <= w;
        if (mem_write) begin
            wr_pulses <= wr_pulses + 1;
            case (mem_funct3[1:0])
                2'b00: w[8*mem_addr[1:0] +: 8] = mem_din[7:0];
                2'b01: w[16*mem_addr[1] +: 16] = mem_din[15:0];
                default: w = mem_din;
            endcase
            mem[mem_addr[12:2]] <= w;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0;
        d_funct3 = 3'b010; d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        idle_in();
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 + i;
        reset = 0;
        idle_in();
        i_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_i_gnt", {31'd0, i_gnt}, 0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 0);
        chk("rst_mem_write", {31'd0, mem_write}, 0);
        chk("rst_mem_addr", {19'd0, mem_addr}, 0);
        chk("rst_mem_f3", {29'd0, mem_funct3}, 3'b010);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_i_rvalid", {31'd0, i_rvalid}, 0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 0);
        reset = 1;
        i_req = 0;

        // Fetch-only
        @(negedge clk);
        i_req = 1; i_addr = 13'h000;
        #1 chk("f0_gnt", {31'd0, i_gnt}, 1);
        chk("f0_f3", {29'd0, mem_funct3}, 3'b010);
        chk("f0_we", {31'd0, mem_write}, 0);
        @(negedge clk);
        chk("f0_rvalid", {31'd0, i_rvalid}, 1);
        chk("f0_rdata", i_rdata, 32'hA000_0000);
        chk("f0_d_rvalid", {31'd0, d_rvalid}, 0);
        i_addr = 13'h004;
        #1 chk("f1_gnt", {31'd0, i_gnt}, 1);
        @(negedge clk);
        chk("f1_rvalid", {31'd0, i_rvalid}, 1);
        chk("f1_rdata", i_rdata, 32'hA000_0001);
        i_req = 0;
        @(negedge clk);
        chk("f_idle_rvalid", {31'd0, i_rvalid}, 0);
        chk("f_idle_rdata", i_rdata, 0);
        chk("f_hold_addr", {19'd0, mem_addr}, 13'h004);

        // Contention: D,I,D,I
        do_reset();
        i_req = 1; d_req = 1;
        i_addr = 13'h008; d_addr = 13'h010;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("c%0d_d_gnt", k), {31'd0, d_gnt}, (k % 2 == 0));
            chk($sformatf("c%0d_i_gnt", k), {31'd0, i_gnt}, (k % 2 == 1));
            @(negedge clk);
            if (k % 2 == 0) begin
                chk($sformatf("c%0d_d_rv", k), {31'd0, d_rvalid}, 1);
                chk($sformatf("c%0d_d_rd", k), d_rdata, 32'hA000_0004);
                chk($sformatf("c%0d_i_rv", k), {31'd0, i_rvalid}, 0);
            end else begin
                chk($sformatf("c%0d_i_rv", k), {31'd0, i_rvalid}, 1);
                chk($sformatf("c%0d_i_rd", k), i_rdata, 32'hA000_0002);
                chk($sformatf("c%0d_d_rv", k), {31'd0, d_rvalid}, 0);
            end
        end
        idle_in();
        #1 chk("c_hold_addr", {19'd0, mem_addr}, 13'h008);
        chk("c_hold_f3", {29'd0, mem_funct3}, 3'b010);

        // Store word then load it back
        @(negedge clk);
        wr_pulses = 0;
        d_req = 1; d_we = 1; d_funct3 = 3'b010;
        d_addr = 13'h1804; d_wdata = 32'hDEAD_BEEF;
        #1 chk("sw_gnt", {31'd0, d_gnt}, 1);
        chk("sw_we", {31'd0, mem_write}, 1);
        chk("sw_din", mem_din, 32'hDEAD_BEEF);
        chk("sw_addr", {19'd0, mem_addr}, 13'h1804);
        @(negedge clk);
        chk("sw_rvalid", {31'd0, d_rvalid}, 1);
        chk("sw_rdata", d_rdata, 0);
        chk("sw_err", {31'd0, d_err}, 0);
        d_we = 0;
        #1 chk("lw_we", {31'd0, mem_write}, 0);
        @(negedge clk);
        chk("lw_rvalid", {31'd0, d_rvalid}, 1);
        chk("lw_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("lw_err", {31'd0, d_err}, 0);
        chk("sw_pulses", wr_pulses, 1);
        d_req = 0;

        // Misaligned LW, misaligned SH, illegal size
        @(negedge clk);
        d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 13'h0006;
        #1 chk("mlw_gnt", {31'd0, d_gnt}, 1);
        chk("mlw_we", {31'd0, mem_write}, 0);
        @(negedge clk);
        chk("mlw_rvalid", {31'd0, d_rvalid}, 1);
        chk("mlw_err", {31'd0, d_err}, 1);
        chk("mlw_rdata", d_rdata, 0);
        d_we = 1; d_funct3 = 3'b001; d_addr = 13'h0003; d_wdata = 32'h1234;
        #1 chk("msh_gnt", {31'd0, d_gnt}, 1);
        chk("msh_we", {31'd0, mem_write}, 0);
        @(negedge clk);
        chk("msh_rvalid", {31'd0, d_rvalid}, 1);
        chk("msh_err", {31'd0, d_err}, 1);
        chk("msh_rdata", d_rdata, 0);
        d_we = 0; d_funct3 = 3'b011; d_addr = 13'h0000;
        @(negedge clk);
        chk("ill_err", {31'd0, d_err}, 1);
        d_req = 0;
        @(negedge clk);
        chk("m_pulses", wr_pulses, 1);
        chk("m_mem0", mem[0], 32'hA000_0000);
        chk("m_err_clr", {31'd0, d_err}, 0);

        // Reset while a load response is due
        d_req = 1; d_funct3 = 3'b010; d_addr = 13'h1804;
        #1 chk("rl_gnt", {31'd0, d_gnt}, 1);
        @(negedge clk);
        reset = 0; d_req = 0;
        #1 chk("rl_rvalid", {31'd0, d_rvalid}, 0);
        chk("rl_rdata", d_rdata, 0);
        chk("rl_err", {31'd0, d_err}, 0);
        @(negedge clk);
        chk("rl_addr", {19'd0, mem_addr}, 0);
        chk("rl_f3", {29'd0, mem_funct3}, 3'b010);
        reset = 1;
        @(negedge clk);
        chk("rl_post_rvalid", {31'd0, d_rvalid}, 0);
        chk("rl_post_irv", {31'd0, i_rvalid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning byte-address width of the shared memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port i_req, input, 1, instruction-fetch read request.
REQ-006 The block SHALL have port i_addr, input, ADDR_W, fetch byte address.
REQ-007 The block SHALL have port i_gnt, output, 1, fetch accepted this cycle.
REQ-008 The block SHALL have port i_rvalid, output, 1, fetch data valid.
REQ-009 The block SHALL have port i_rdata, output, DATA_W, fetch data.
REQ-010 The block SHALL have port d_req, input, 1, load/store request.
REQ-011 The block SHALL have port d_we, input, 1, store when 1.
REQ-012 The block SHALL have port d_funct3, input, 3, access size/sign code (RV32 load/store encoding).
REQ-013 The block SHALL have port d_addr, input, ADDR_W, data byte address.
REQ-014 The block SHALL have port d_wdata, input, DATA_W, store data.
REQ-015 The block SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-016 The block SHALL have port d_rvalid, output, 1, data response valid (load data or store ack).
REQ-017 The block SHALL have port d_rdata, output, DATA_W, load data.
REQ-018 The block SHALL have port d_err, output, 1, misaligned/illegal access, qualified by d_rvalid.
REQ-019 The block SHALL have ports mem_write (out, 1), mem_funct3 (out, 3), mem_addr (out, ADDR_W), mem_din (out, DATA_W), mem_dout (in, DATA_W), driving the banked memory.

Function
REQ-020 A request SHALL be accepted in the cycle req and gnt are both 1; gnt SHALL be combinational from req and arbitration state, and at most one gnt SHALL be 1 per cycle.
REQ-021 With one requester active, that requester SHALL be granted; with both active, the requester not granted most recently SHALL win (round-robin), and the last-grant pointer SHALL update only on an accepted request.
REQ-022 On an accepted request, mem_addr/mem_funct3/mem_din SHALL be driven that cycle; fetch SHALL use mem_funct3 = 3'b010 and mem_write = 0.
REQ-023 mem_write SHALL be 1 only in the grant cycle of an aligned store; otherwise 0.
REQ-024 When no request is accepted, mem_addr and mem_funct3 SHALL hold their last driven values so the bank-select read mux stays stable during the response cycle.
REQ-025 The response SHALL arrive exactly one cycle after acceptance: rvalid = 1 for one cycle, rdata = mem_dout in that cycle; back-to-back accepts SHALL yield back-to-back responses (throughput 1/cycle).
REQ-026 Store responses SHALL assert d_rvalid with d_rdata = 0.
REQ-027 A data access SHALL be misaligned when d_funct3[1:0]=01 and d_addr[0]=1, or d_funct3[1:0]=10 and d_addr[1:0]!=0; d_funct3[1:0]=11 SHALL be illegal.
REQ-028 Misaligned/illegal accesses SHALL be granted, SHALL NOT write memory, and SHALL return d_rvalid=1, d_err=1, d_rdata=0 next cycle.
REQ-029 Response routing SHALL be held in a state register with states NONE, RSP_I, RSP_D, RSP_DERR; it SHALL load the grant type each cycle, or NONE when nothing is accepted.
REQ-030 Non-responding rvalid/rdata/d_err outputs SHALL be 0.

Reset
REQ-031 While reset=0 at a clk edge: state <- NONE, pointer <- "fetch last" (data wins first tie), mem_addr <- 0, mem_funct3 <- 3'b010, mem_din <- 0.
REQ-032 During reset, all gnt, rvalid, d_err, and mem_write SHALL be 0; a response pending at reset assertion SHALL be dropped.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the response-state enum and the funct3 size constants (BYTE=00, HALF=01, WORD=10).
REQ-034 The two-way round-robin grant logic SHALL be a sub-module rr_arb2 (req[1:0], accept, gnt[1:0]).

Verification
REQ-035 Fetch-only: i_req with i_addr=0x000, then 0x004 -> i_gnt both cycles, i_rvalid on the following two cycles with the stored words.
REQ-036 Contention: i_req=d_req=1 for 4 cycles after reset -> grant order D,I,D,I; each response is routed to the correct port.
REQ-037 Store then load: SW 0xDEADBEEF to 0x1804, then LW 0x1804 -> mem_write pulses once; d_rdata=0xDEADBEEF, d_err=0.
REQ-038 Misaligned: LW at 0x0006 and SH at 0x0003 -> mem_write=0, d_rvalid=1, d_err=1, d_rdata=0.
REQ-039 Reset mid-operation: reset=0 the cycle after a granted load -> no d_rvalid; all outputs at reset values.
